// File: rtl/tbus_pkg.sv
// Shared definitions for the single-wire tristate bus: receiver states,
// the released-line level and the default frame geometry.
package tbus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } state_e;

   localparam logic BUS_IDLE = 1'b1;

   localparam int DEF_CLKS_PER_BIT = 4;
   localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/tbus_sync.sv
// Two-flop synchronizer for the asynchronous bus line; both flops reset to
// the released level so reset never looks like a start bit.
module tbus_sync
   import tbus_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= BUS_IDLE;
         sync_q <= BUS_IDLE;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/tristate_bus_rx.sv
// Listening end of the shared tristate bus: start-bit qualification,
// LSB-first deserialization, stop-bit check and one-cycle result strobes.
module tristate_bus_rx
   import tbus_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bus,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   logic                 busSync;
   state_e               state_q, state_d;
   logic [CW-1:0]        bitCnt_q, bitCnt_d;
   logic [IW-1:0]        bitIdx_q, bitIdx_d;
   logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
   logic [DATA_BITS-1:0] dataReg_q, dataReg_d;
   logic                 valid_q, valid_d;
   logic                 frameErr_q, frameErr_d;

   tbus_sync uSync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (bus),
      .q_o    (busSync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         bitIdx_q   <= '0;
         shiftReg_q <= '0;
         dataReg_q  <= '0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         bitIdx_q   <= bitIdx_d;
         shiftReg_q <= shiftReg_d;
         dataReg_q  <= dataReg_d;
         valid_q    <= valid_d;
         frameErr_q <= frameErr_d;
      end
   end

   // The start bit is sampled at mid-bit; every later sample lands one full
   // bit period later, so the counter wraps to zero at each sample point.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q + CW'(1);
      bitIdx_d   = bitIdx_q;
      shiftReg_d = shiftReg_q;
      dataReg_d  = dataReg_q;
      valid_d    = 1'b0;
      frameErr_d = 1'b0;
      case (state_q)
         IDLE: begin
            bitCnt_d = '0;
            bitIdx_d = '0;
            if (busSync != BUS_IDLE) begin
               state_d = START;
            end
         end
         START: begin
            if (bitCnt_q == HALF_LAST) begin
               bitCnt_d = '0;
               bitIdx_d = '0;
               state_d  = (busSync == BUS_IDLE) ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bitCnt_q == BIT_LAST) begin
               bitCnt_d             = '0;
               shiftReg_d[bitIdx_q] = busSync;
               if (bitIdx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + IW'(1);
               end
            end
         end
         STOP: begin
            if (bitCnt_q == BIT_LAST) begin
               bitCnt_d = '0;
               if (busSync == BUS_IDLE) begin
                  dataReg_d = shiftReg_q;
                  valid_d   = 1'b1;
                  state_d   = IDLE;
               end else begin
                  frameErr_d = 1'b1;
                  state_d    = WAIT_HI;
               end
            end
         end
         WAIT_HI: begin
            bitCnt_d = '0;
            if (busSync == BUS_IDLE) begin
               state_d = IDLE;
            end
         end
         default: begin
            bitCnt_d = '0;
            state_d  = IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      data      = dataReg_q;
      valid     = valid_q;
      frame_err = frameErr_q;
   end

endmodule

// File: tb/tb_tristate_bus_rx.sv
// Directed bench for tristate_bus_rx: a pulled-up bus net driven through an
// enable-gated tristate buffer, with hand-computed expectations.
module tb_tristate_bus_rx;

   localparam int CPB = 4;
   localparam int DB  = 8;
   // Drive-to-strobe latency: 2 sync + 1 IDLE edge + half bit + 9 bits.
   localparam int LAT = 3 + CPB / 2 + (DB + 1) * CPB;

   logic          clk;
   logic          rst_n;
   logic          busEn;
   logic          busDrv;
   wire           bus;
   logic [DB-1:0] data;
   logic          valid;
   logic          frame_err;
   logic          busy;

   pullup (bus);
   assign bus = busEn ? busDrv : 1'bz;

   tristate_bus_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   int checkCount = 0;
   int passCount  = 0;

   int            validHighCycles = 0;
   int            ferrHighCycles  = 0;
   int            busyCycles      = 0;
   int            bothCycles      = 0;
   logic          prevValid       = 1'b0;
   logic          prevFerr        = 1'b0;
   int            validCycleLog[$];
   logic [DB-1:0] validDataLog[$];
   int            ferrCycleLog[$];
   int            lastFrameStart  = 0;

   // Passive observer: strobe widths, strobe times and captured words.
   always @(negedge clk) begin
      if (valid) begin
         validHighCycles++;
         if (!prevValid) begin
            validCycleLog.push_back(cycleCnt);
            validDataLog.push_back(data);
         end
      end
      if (frame_err) begin
         ferrHighCycles++;
         if (!prevFerr) ferrCycleLog.push_back(cycleCnt);
      end
      if (busy) busyCycles++;
      if (valid && frame_err) bothCycles++;
      prevValid = valid;
      prevFerr  = frame_err;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives start, data LSB first and the given stop level; leaves the
   // buffer enabled so callers decide what the line does afterwards.
   task automatic applyStimulus(input logic [DB-1:0] word, input logic stopBit);
      lastFrameStart = cycleCnt;
      busEn  = 1'b1;
      busDrv = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < DB; i++) begin
         busDrv = word[i];
         waitCycles(CPB);
      end
      busDrv = stopBit;
      waitCycles(CPB);
   endtask

   int nValid, nFerr, nHigh, nFerrHigh, nBusy, s1;

   initial begin
      rst_n  = 1'b0;
      busEn  = 1'b0;
      busDrv = 1'b1;
      waitCycles(3);
      #1;
      checkOutput("reset_data", 32'(data), 32'h0);
      checkOutput("reset_valid", 32'(valid), 32'h0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      waitCycles(5);
      #1;

      $display("[TB] frame 0xA5");
      applyStimulus(8'hA5, 1'b1);
      busEn = 1'b0;
      waitCycles(6);
      #1;
      checkOutput("a5_valid_pulses", 32'(validCycleLog.size()), 32'd1);
      checkOutput("a5_valid_width", 32'(validHighCycles), 32'd1);
      if (validCycleLog.size() > 0)
         checkOutput("a5_valid_time", 32'(validCycleLog[0]), 32'(lastFrameStart + LAT));
      checkOutput("a5_data", 32'(data), 32'hA5);
      checkOutput("a5_no_ferr", 32'(ferrCycleLog.size()), 32'd0);
      checkOutput("a5_idle_busy", 32'(busy), 32'h0);

      $display("[TB] one-cycle glitch");
      nValid = validCycleLog.size();
      nFerr  = ferrCycleLog.size();
      nBusy  = busyCycles;
      busEn  = 1'b1;
      busDrv = 1'b0;
      @(negedge clk);
      busEn  = 1'b0;
      busDrv = 1'b1;
      waitCycles(10);
      #1;
      checkOutput("glitch_busy_cycles", 32'(busyCycles - nBusy), 32'd2);
      checkOutput("glitch_no_valid", 32'(validCycleLog.size() - nValid), 32'd0);
      checkOutput("glitch_no_ferr", 32'(ferrCycleLog.size() - nFerr), 32'd0);
      checkOutput("glitch_idle_busy", 32'(busy), 32'h0);
      checkOutput("glitch_data_kept", 32'(data), 32'hA5);

      $display("[TB] frame 0x3C with stop low");
      nValid    = validCycleLog.size();
      nFerr     = ferrCycleLog.size();
      nFerrHigh = ferrHighCycles;
      applyStimulus(8'h3C, 1'b0);
      waitCycles(10);
      #1;
      checkOutput("ferr_pulses", 32'(ferrCycleLog.size() - nFerr), 32'd1);
      checkOutput("ferr_width", 32'(ferrHighCycles - nFerrHigh), 32'd1);
      if (ferrCycleLog.size() > nFerr)
         checkOutput("ferr_time", 32'(ferrCycleLog[nFerr]), 32'(lastFrameStart + LAT));
      checkOutput("ferr_data_kept", 32'(data), 32'hA5);
      checkOutput("ferr_no_valid", 32'(validCycleLog.size() - nValid), 32'd0);
      checkOutput("ferr_wait_hi_busy", 32'(busy), 32'h1);
      busEn = 1'b0;
      waitCycles(10);
      #1;
      checkOutput("ferr_release_idle", 32'(busy), 32'h0);
      checkOutput("ferr_release_no_valid", 32'(validCycleLog.size() - nValid), 32'd0);
      checkOutput("ferr_release_no_ferr", 32'(ferrCycleLog.size() - nFerr), 32'd1);

      $display("[TB] back-to-back 0x00, 0xFF");
      nValid = validCycleLog.size();
      nHigh  = validHighCycles;
      applyStimulus(8'h00, 1'b1);
      s1 = lastFrameStart;
      applyStimulus(8'hFF, 1'b1);
      busEn = 1'b0;
      waitCycles(6);
      #1;
      checkOutput("b2b_pulses", 32'(validCycleLog.size() - nValid), 32'd2);
      checkOutput("b2b_width", 32'(validHighCycles - nHigh), 32'd2);
      if (validCycleLog.size() >= nValid + 2) begin
         checkOutput("b2b_first_data", 32'(validDataLog[nValid]), 32'h00);
         checkOutput("b2b_second_data", 32'(validDataLog[nValid + 1]), 32'hFF);
         checkOutput("b2b_first_time", 32'(validCycleLog[nValid]), 32'(s1 + LAT));
         checkOutput("b2b_spacing", 32'(validCycleLog[nValid + 1] - validCycleLog[nValid]), 32'd40);
      end
      checkOutput("b2b_data", 32'(data), 32'hFF);

      $display("[TB] reset during data bit 4 of 0x5A");
      nValid = validCycleLog.size();
      nFerr  = ferrCycleLog.size();
      busEn  = 1'b1;
      busDrv = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 4; i++) begin
         busDrv = 1'((8'h5A >> i) & 8'h01);
         waitCycles(CPB);
      end
      busDrv = 1'b1;
      waitCycles(CPB / 2);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_data", 32'(data), 32'h0);
      checkOutput("midrst_valid", 32'(valid), 32'h0);
      checkOutput("midrst_frame_err", 32'(frame_err), 32'h0);
      checkOutput("midrst_busy", 32'(busy), 32'h0);
      busEn = 1'b0;
      waitCycles(2);
      rst_n = 1'b1;
      waitCycles(50);
      #1;
      checkOutput("midrst_no_valid", 32'(validCycleLog.size() - nValid), 32'd0);
      checkOutput("midrst_no_ferr", 32'(ferrCycleLog.size() - nFerr), 32'd0);
      applyStimulus(8'h81, 1'b1);
      busEn = 1'b0;
      waitCycles(6);
      #1;
      checkOutput("post_rst_pulses", 32'(validCycleLog.size() - nValid), 32'd1);
      checkOutput("post_rst_data", 32'(data), 32'h81);

      $display("[TB] released bus for 100 cycles");
      nValid = validCycleLog.size();
      nFerr  = ferrCycleLog.size();
      nBusy  = busyCycles;
      waitCycles(100);
      #1;
      checkOutput("idle_busy_cycles", 32'(busyCycles - nBusy), 32'd0);
      checkOutput("idle_no_valid", 32'(validCycleLog.size() - nValid), 32'd0);
      checkOutput("idle_no_ferr", 32'(ferrCycleLog.size() - nFerr), 32'd0);
      checkOutput("idle_data_kept", 32'(data), 32'h81);

      checkOutput("never_valid_and_ferr", 32'(bothCycles), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tristate_bus_rx.md
# tristate_bus_rx

Serial receiver for the shared single-wire tristate bus. Transmitters drive the bus through an enable-gated tristate buffer: they drive data while enabled and present z otherwise. A top-level pullup idles the released line high. This block is the listening end: it detects a start bit, deserializes a fixed-length LSB-first frame, checks the stop bit, and presents the byte with a one-cycle strobe.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per bit; must be even and ≥ 4.
- DATA_BITS, default 8: data bits per frame.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- bus  input  1  shared tristate line; reads 1 when released.
- data  output  DATA_BITS  last good received word, LSB = first bit on the line.
- valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high in any state other than IDLE.

## Operation
- Input path: bus → 2-flop synchronizer → bus_s. All decisions use bus_s only.
- Frame on the line: start (0), DATA_BITS data bits LSB first, stop (1). Each bit lasts CLKS_PER_BIT cycles.
- States:
  - IDLE: bus_s==0 → START; counter cleared.
  - START: count CLKS_PER_BIT/2 cycles, then sample. If bus_s==0 → DATA (bit index 0). If bus_s==1 (glitch) → IDLE, with no strobe.
  - DATA: every CLKS_PER_BIT cycles, sample bus_s into shift register bit [idx]. After bit DATA_BITS-1 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If 1 → load data from the shift register, pulse valid, go to IDLE. If 0 → pulse frame_err, leave data unchanged, go to WAIT_HI.
  - WAIT_HI: stay until bus_s==1, then → IDLE. This blocks re-triggering on a stuck-low line.
- Bit counter width: $clog2(CLKS_PER_BIT). Bit-index width: $clog2(DATA_BITS). The counter wraps to 0 at each sample.
- valid and frame_err are never high in the same cycle.
- Reset (asynchronous, any state, mid-frame included):
  - state=IDLE; synchronizer flops = 1.
  - data=0, valid=0, frame_err=0, busy=0.
  - A partial frame is discarded. After reset release, the next falling edge on bus_s starts a new frame.

## Timing
- Synchronizer latency is 2 cycles from bus to bus_s.
- Let t0 be the first edge where bus_s==0 in IDLE. Then:
  - start sample at t0+CLKS_PER_BIT/2;
  - data bit k sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT;
  - stop sampled at t0+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT.
- valid / frame_err are registered: high in the cycle after the stop sample, for exactly one cycle. data changes in that same cycle.
- A start bit that begins immediately after the stop sample is accepted: IDLE sees bus_s==0 on the next edge. This gives full back-to-back throughput.
- A low pulse shorter than CLKS_PER_BIT/2 cycles, after synchronization, is rejected as a glitch.

## Structure
- Package tbus_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HI};
  - constant BUS_IDLE = 1'b1;
  - default localparams for CLKS_PER_BIT and DATA_BITS, shared with the transmitter side.
- Sub-module tbus_sync: 2-flop synchronizer with reset value 1.
- The FSM, counters and shift register live in tristate_bus_rx.
- The bench places a pullup on the bus net and drives it through an enable-gated tristate buffer, so the line is z whenever the enable is 0.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DATA_BITS=8.
- Frame 0xA5 driven (en=1 during the frame, en=0 afterwards) → data=8'hA5; valid high for exactly 1 cycle, 2+2+9·4 cycles after the driven falling edge plus 1; frame_err=0.
- Line driven low for 1 cycle, then released → busy rises, returns to IDLE; no valid, no frame_err.
- Frame 0x3C with stop bit driven 0, held low 10 cycles, then released → frame_err pulses once; data keeps its previous value; no new frame starts until the line goes high.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two valid pulses, 40 cycles apart; data=0x00, then 0xFF.
- rst_n pulsed low in the middle of data bit 4 of frame 0x5A → all outputs 0 immediately; no valid for that frame; next frame 0x81 received correctly.
- Bus released (z, pulled high) for 100 cycles → busy=0, valid=0, frame_err=0 throughout.
